// File: rtl/ecdsa_uop_sequencer.sv
// Microprogram sequencer for the ECDSA point engine.
// Walks the externally muxed microcode ROM from address 0, decodes each
// micro-op, evaluates its execution condition against the latched compare
// flag, issues enabled ops to the modular-arithmetic worker and waits for
// completion. A program ends on the first RDY opcode; running off the end
// of the ROM or a worker timeout aborts with err set.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | program done or never started; rdy high, waits for ena
//   S_FETCH  | rom_addr presented, one cycle of ROM read latency
//   S_DECODE | rom_data valid; latch fields, check RDY and exec condition
//   S_ISSUE  | uop_ena strobe for exactly one cycle, timeout counter loaded
//   S_WAIT   | fields held, waiting for uop_rdy or timeout
module ecdsa_uop_sequencer #(
    parameter int         UOP_W      = 20,
    parameter int         ADDR_W     = 6,
    parameter logic [3:0] OPCODE_RDY = 4'd0,
    parameter logic [3:0] OPCODE_CMP = 4'd1,
    parameter int         TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    output logic              rdy,
    output logic              err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [UOP_W-1:0]  rom_data,
    output logic [3:0]        uop_opcode,
    output logic [4:0]        uop_src1,
    output logic [4:0]        uop_src2,
    output logic [3:0]        uop_dst,
    output logic              uop_ena,
    input  logic              uop_rdy,
    input  logic              uop_cmp_eq,
    output logic              cmp_flag
);

    localparam int            TMO_W    = 10;
    // Down-counter is loaded with TIMEOUT-1 so that the abort lands exactly
    // TIMEOUT cycles after entering WAIT.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             exec_ok;
    logic             last_addr;
    logic             tmo_done;
    logic [3:0]       dec_opcode;
    logic [1:0]       dec_exec;

    assign dec_opcode = rom_data[19:16];
    assign dec_exec   = rom_data[1:0];
    assign last_addr  = (rom_addr == {ADDR_W{1'b1}});
    assign tmo_done   = (tmo_cnt == '0);

    // Execution condition of the op on rom_data; 2'b11 is reserved and runs unconditionally.
    always_comb begin
        exec_ok = 1'b1;
        case (dec_exec)
            2'b01:   exec_ok = cmp_flag;
            2'b10:   exec_ok = ~cmp_flag;
            default: exec_ok = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the two state-derived outputs.
    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        uop_ena   = 1'b0;
        case (state)
            S_IDLE: begin
                rdy = 1'b1;
                if (ena) state_nxt = S_FETCH;
            end
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                if (dec_opcode == OPCODE_RDY) state_nxt = S_IDLE;
                else if (exec_ok)             state_nxt = S_ISSUE;
                else if (last_addr)           state_nxt = S_IDLE;
                else                          state_nxt = S_FETCH;
            end
            S_ISSUE: begin
                uop_ena   = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (uop_rdy)       state_nxt = last_addr ? S_IDLE : S_FETCH;
                else if (tmo_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address, latched fields, compare flag, error flag and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            uop_opcode <= '0;
            uop_src1   <= '0;
            uop_src2   <= '0;
            uop_dst    <= '0;
            cmp_flag   <= 1'b0;
            err        <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ena) begin
                        rom_addr <= '0;
                        err      <= 1'b0;
                        cmp_flag <= 1'b0;
                    end
                end
                S_DECODE: begin
                    uop_opcode <= dec_opcode;
                    uop_src1   <= rom_data[15:11];
                    uop_src2   <= rom_data[10:6];
                    uop_dst    <= rom_data[5:2];
                    if (dec_opcode != OPCODE_RDY && !exec_ok) begin
                        if (last_addr) err      <= 1'b1;
                        else           rom_addr <= rom_addr + 1'b1;
                    end
                end
                S_ISSUE: tmo_cnt <= TMO_LOAD;
                S_WAIT: begin
                    if (uop_rdy) begin
                        if (uop_opcode == OPCODE_CMP) cmp_flag <= uop_cmp_eq;
                        if (last_addr) err      <= 1'b1;
                        else           rom_addr <= rom_addr + 1'b1;
                    end else if (tmo_done) begin
                        err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
